// File: rtl/la_bridge_pkg.sv
// la_bridge_pkg
// Shared defaults and helpers for the LA-to-accelerator stream bridge.
//   - default stream/result widths and FIFO depths
//   - ptr_w(): FIFO pointer width for a given depth (address bits plus wrap bit)
//   - LA bit-slot constants used when wiring la_data_in/la_data_out in the wrapper
package la_bridge_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_RES_W     = 8;
    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_IN_DEPTH  = 4;
    localparam int DEF_RES_DEPTH = 8;
    localparam int DEF_SEL_W     = 2;

    // LA slot positions: ch0 carries weights, ch1 carries line data.
    localparam int LA_SLOT_W     = 8;
    localparam int LA_WEIGHT_LSB = 0;
    localparam int LA_LINE_LSB   = 8;
    localparam int LA_RES_LSB    = 16;

    // One extra pointer bit distinguishes full from empty after wrap-around.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/la_sync_fifo.sv
// la_sync_fifo
// Single-clock FIFO, DEPTH must be a power of two >= 2.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata    write request and data; taken when not full, or when full
//                  and a pop happens in the same cycle
//   pop            read request; ignored while empty
//   head           oldest word, forced to 0 while empty
//   full, empty    occupancy flags
module la_sync_fifo
    import la_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int            PW      = ptr_w(DEPTH);
    localparam int            AW      = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/la_stream_bridge.sv
// la_stream_bridge
// Bridges the slow Logic Analyzer interface to the accelerator core.
// LA pushes words into NUM_CH input FIFOs with a toggle handshake; the
// accelerator drains them with valid/ready. Results flow back through one
// FIFO that the LA pops with a second toggle. Sticky flags record dropped
// pushes, bad channel selects and pops on an empty result FIFO.
// Optional macro LA_STREAM_BRIDGE_SYNC_EN: when defined, all LA-side inputs
// (data, sel, both toggles, clr) pass through 2-flop synchronisers first.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   la_in_data/sel/toggle, la_in_ack  LA push request and its echo
//   ch_data/ch_valid/ch_ready       per-channel stream to the accelerator
//   res_data/res_valid/res_ready    result stream from the accelerator
//   la_res_data/la_res_valid        result FIFO head toward the LA
//   la_res_pop_toggle               LA pop request (level change)
//   la_clr                          clears sticky flags
//   err_ovf/err_sel/err_unf         sticky error flags
module la_stream_bridge
    import la_bridge_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RES_W     = DEF_RES_W,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int IN_DEPTH  = DEF_IN_DEPTH,
    parameter int RES_DEPTH = DEF_RES_DEPTH,
    parameter int SEL_W     = DEF_SEL_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        la_in_data,
    input  logic [SEL_W-1:0]         la_in_sel,
    input  logic                     la_in_toggle,
    output logic                     la_in_ack,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_ready,
    input  logic [RES_W-1:0]         res_data,
    input  logic                     res_valid,
    output logic                     res_ready,
    output logic [RES_W-1:0]         la_res_data,
    output logic                     la_res_valid,
    input  logic                     la_res_pop_toggle,
    input  logic                     la_clr,
    output logic [NUM_CH-1:0]        err_ovf,
    output logic                     err_sel,
    output logic                     err_unf
);

    localparam int SYNC_W = DATA_W + SEL_W + 3;

    logic [SYNC_W-1:0] raw_in;
    logic [SYNC_W-1:0] use_in;
    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_sel;
    logic              in_tog;
    logic              pop_tog;
    logic              clr;

    assign raw_in = {la_in_data, la_in_sel, la_in_toggle, la_res_pop_toggle, la_clr};

`ifdef LA_STREAM_BRIDGE_SYNC_EN
    for (genvar b = 0; b < SYNC_W; b++) begin : g_sync
        logic meta;
        logic stable;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                meta   <= 1'b0;
                stable <= 1'b0;
            end else begin
                meta   <= raw_in[b];
                stable <= meta;
            end
        end
        assign use_in[b] = stable;
    end
`else
    assign use_in = raw_in;
`endif

    assign {in_data, in_sel, in_tog, pop_tog, clr} = use_in;

    // Input path
    logic              tog_q;
    logic              push_req;
    logic              sel_ok;
    logic [NUM_CH-1:0] ch_full;
    logic [NUM_CH-1:0] ch_empty;
    logic [NUM_CH-1:0] ch_pop;
    logic [NUM_CH-1:0] ch_push;
    logic [NUM_CH-1:0] ovf_evt;

    assign push_req = in_tog ^ tog_q;
    assign sel_ok   = (int'(in_sel) < NUM_CH);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic hit;
        assign hit         = push_req && sel_ok && (int'(in_sel) == k);
        assign ch_valid[k] = !ch_empty[k];
        assign ch_pop[k]   = ch_valid[k] && ch_ready[k];
        // A full channel still takes the word when its head leaves this cycle.
        assign ch_push[k]  = hit && (!ch_full[k] || ch_pop[k]);
        assign ovf_evt[k]  = hit && ch_full[k] && !ch_pop[k];

        la_sync_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (IN_DEPTH)
        ) u_in_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (ch_push[k]),
            .pop     (ch_pop[k]),
            .wdata   (in_data),
            .head    (ch_data[k*DATA_W +: DATA_W]),
            .full    (ch_full[k]),
            .empty   (ch_empty[k])
        );
    end

    // Result path
    logic resq_q;
    logic pop_req;
    logic res_pop;
    logic res_push;
    logic res_full;
    logic res_empty;

    assign pop_req      = pop_tog ^ resq_q;
    assign res_pop      = pop_req && !res_empty;
    assign res_ready    = !res_full || res_pop;
    assign res_push     = res_valid && res_ready;
    assign la_res_valid = !res_empty;

    la_sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (res_push),
        .pop     (res_pop),
        .wdata   (res_data),
        .head    (la_res_data),
        .full    (res_full),
        .empty   (res_empty)
    );

    // Toggle history, ack echo and sticky flags. A new error in the same
    // cycle as clr keeps its flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tog_q     <= 1'b0;
            resq_q    <= 1'b0;
            la_in_ack <= 1'b0;
            err_ovf   <= '0;
            err_sel   <= 1'b0;
            err_unf   <= 1'b0;
        end else begin
            tog_q     <= in_tog;
            resq_q    <= pop_tog;
            la_in_ack <= in_tog;
            err_ovf   <= (err_ovf & {NUM_CH{!clr}}) | ovf_evt;
            err_sel   <= (err_sel && !clr) || (push_req && !sel_ok);
            err_unf   <= (err_unf && !clr) || (pop_req && res_empty);
        end
    end

endmodule

// File: tb/tb_la_stream_bridge.sv
module tb_la_stream_bridge;

    localparam int DATA_W    = 8;
    localparam int RES_W     = 8;
    localparam int NUM_CH    = 2;
    localparam int IN_DEPTH  = 4;
    localparam int RES_DEPTH = 8;
    localparam int SEL_W     = 2;

    logic                     clk;
    logic                     reset_n;
    logic [DATA_W-1:0]        la_in_data;
    logic [SEL_W-1:0]         la_in_sel;
    logic                     la_in_toggle;
    logic                     la_in_ack;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_ready;
    logic [RES_W-1:0]         res_data;
    logic                     res_valid;
    logic                     res_ready;
    logic [RES_W-1:0]         la_res_data;
    logic                     la_res_valid;
    logic                     la_res_pop_toggle;
    logic                     la_clr;
    logic [NUM_CH-1:0]        err_ovf;
    logic                     err_sel;
    logic                     err_unf;

    la_stream_bridge #(
        .DATA_W    (DATA_W),
        .RES_W     (RES_W),
        .NUM_CH    (NUM_CH),
        .IN_DEPTH  (IN_DEPTH),
        .RES_DEPTH (RES_DEPTH),
        .SEL_W     (SEL_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .la_in_data        (la_in_data),
        .la_in_sel         (la_in_sel),
        .la_in_toggle      (la_in_toggle),
        .la_in_ack         (la_in_ack),
        .ch_data           (ch_data),
        .ch_valid          (ch_valid),
        .ch_ready          (ch_ready),
        .res_data          (res_data),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .la_res_data       (la_res_data),
        .la_res_valid      (la_res_valid),
        .la_res_pop_toggle (la_res_pop_toggle),
        .la_clr            (la_clr),
        .err_ovf           (err_ovf),
        .err_sel           (err_sel),
        .err_unf           (err_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: word queues (scoreboard) plus occupancy and flags.
    logic [DATA_W-1:0] chq [NUM_CH][$];
    logic [RES_W-1:0]  rq [$];
    int                cnt [NUM_CH];
    int                rcnt;
    logic              m_tog, m_resq, m_ack, m_sel, m_unf;
    logic [NUM_CH-1:0] m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic post_check();
        logic [NUM_CH-1:0] ev;
        for (int k = 0; k < NUM_CH; k++) ev[k] = (cnt[k] > 0);
        check("ch_valid", 32'(ch_valid), 32'(ev));
        for (int k = 0; k < NUM_CH; k++)
            check("ch_head", 32'(ch_data[k*DATA_W +: DATA_W]),
                  (cnt[k] > 0) ? 32'(chq[k][0]) : 32'h0);
        check("la_res_valid", 32'(la_res_valid), 32'(rcnt > 0));
        check("la_res_data", 32'(la_res_data), (rcnt > 0) ? 32'(rq[0]) : 32'h0);
        check("err_ovf", 32'(err_ovf), 32'(m_ovf));
        check("err_sel", 32'(err_sel), 32'(m_sel));
        check("err_unf", 32'(err_unf), 32'(m_unf));
        check("la_in_ack", 32'(la_in_ack), 32'(m_ack));
    endtask

    // Called at posedge+1 with this cycle's inputs already driven.
    task automatic cyc();
        int   sel_i;
        logic req, preq, lpop, rr;
        logic pop_k [NUM_CH];
        #1;
        for (int k = 0; k < NUM_CH; k++) pop_k[k] = (cnt[k] > 0) && ch_ready[k];
        if (la_clr) begin
            m_ovf = '0;
            m_sel = 1'b0;
            m_unf = 1'b0;
        end
        req   = (la_in_toggle != m_tog);
        sel_i = int'(la_in_sel);
        if (req) begin
            if (sel_i >= NUM_CH) m_sel = 1'b1;
            else if (cnt[sel_i] < IN_DEPTH || pop_k[sel_i]) begin
                chq[sel_i].push_back(la_in_data);
                cnt[sel_i]++;
            end else m_ovf[sel_i] = 1'b1;
        end
        for (int k = 0; k < NUM_CH; k++) if (pop_k[k]) cnt[k]--;
        preq = (la_res_pop_toggle != m_resq);
        lpop = preq && (rcnt > 0);
        if (preq && rcnt == 0) m_unf = 1'b1;
        rr = (rcnt < RES_DEPTH) || lpop;
        check("res_ready", 32'(res_ready), 32'(rr));
        if (res_valid && rr) begin
            rq.push_back(res_data);
            rcnt++;
        end
        if (lpop) rcnt--;
        m_tog  = la_in_toggle;
        m_resq = la_res_pop_toggle;
        m_ack  = la_in_toggle;
        @(posedge clk);
        #1;
        post_check();
    endtask

    task automatic push(input int sel, input logic [DATA_W-1:0] d);
        la_in_sel    = SEL_W'(sel);
        la_in_data   = d;
        la_in_toggle = ~la_in_toggle;
        cyc();
    endtask

    task automatic pop_res();
        la_res_pop_toggle = ~la_res_pop_toggle;
        cyc();
    endtask

    task automatic do_reset();
        reset_n           = 1'b0;
        la_in_toggle      = 1'b0;
        la_res_pop_toggle = 1'b0;
        la_clr            = 1'b0;
        res_valid         = 1'b0;
        ch_ready          = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            chq[k].delete();
            cnt[k] = 0;
        end
        rq.delete();
        rcnt   = 0;
        m_tog  = 1'b0;
        m_resq = 1'b0;
        m_ack  = 1'b0;
        m_sel  = 1'b0;
        m_unf  = 1'b0;
        m_ovf  = '0;
        #1;
        post_check();
        check("rst_res_ready", 32'(res_ready), 32'h1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands a word over.
    initial begin
        logic prev_pop;
        prev_pop = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_pop = 1'b0;
                continue;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_valid[k] && ch_ready[k]) begin
                    if (chq[k].size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_ch%0d: got word 0x%0h expected no word", k,
                                 ch_data[k*DATA_W +: DATA_W]);
                    end else check("sb_ch", 32'(ch_data[k*DATA_W +: DATA_W]), 32'(chq[k].pop_front()));
                end
            end
            if (la_res_pop_toggle != prev_pop && la_res_valid) begin
                if (rq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_res: got word 0x%0h expected no word", la_res_data);
                end else check("sb_res", 32'(la_res_data), 32'(rq.pop_front()));
            end
            prev_pop = la_res_pop_toggle;
        end
    end

    initial begin
        reset_n           = 1'b1;
        la_in_data        = '0;
        la_in_sel         = '0;
        la_in_toggle      = 1'b0;
        ch_ready          = '0;
        res_data          = '0;
        res_valid         = 1'b0;
        la_res_pop_toggle = 1'b0;
        la_clr            = 1'b0;
        #2;
        do_reset();
        cyc();

        // Single push to ch1
        push(1, 8'hA5);
        check("a5_valid", 32'(ch_valid), 32'h2);
        check("a5_head", 32'(ch_data[15:8]), 32'hA5);
        check("a5_ack", 32'(la_in_ack), 32'h1);
        ch_ready = 2'b10;
        cyc();
        ch_ready = 2'b00;

        // Overflow on ch0, then clear
        for (int i = 0; i < 5; i++) push(0, 8'(8'h10 + i));
        check("ovf_set", 32'(err_ovf), 32'h1);
        la_clr = 1'b1;
        cyc();
        la_clr = 1'b0;
        check("ovf_clr", 32'(err_ovf), 32'h0);
        ch_ready = 2'b01;
        repeat (4) cyc();
        ch_ready = 2'b00;
        for (int i = 0; i < 4; i++) push(0, 8'(8'h20 + i));
        ch_ready = 2'b01;
        push(0, 8'h24);
        check("full_pop_ovf", 32'(err_ovf), 32'h0);
        repeat (5) cyc();
        ch_ready = 2'b00;

        // Bad select
        push(3, 8'h77);
        check("sel_err", 32'(err_sel), 32'h1);
        check("sel_nochg", 32'(ch_valid), 32'h0);
        check("sel_ack", 32'(la_in_ack), 32'(la_in_toggle));
        la_clr = 1'b1;
        cyc();
        la_clr = 1'b0;

        // Result FIFO fill, drain, underflow
        res_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            res_data = 8'(i);
            cyc();
        end
        check("res_full", 32'(res_ready), 32'h0);
        res_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check("res_order", 32'(la_res_data), 32'(i));
            pop_res();
        end
        res_valid = 1'b1;
        res_data  = 8'h09;
        cyc();
        res_valid = 1'b0;
        check("res_nine", 32'(la_res_data), 32'h09);
        pop_res();
        pop_res();
        check("unf_set", 32'(err_unf), 32'h1);
        la_clr = 1'b1;
        cyc();
        la_clr = 1'b0;

        // Reset with words queued
        for (int i = 0; i < 3; i++) push(1, 8'(8'h50 + i));
        do_reset();
        check("rst_mid_valid", 32'(ch_valid), 32'h0);
        push(0, 8'h3C);
        check("post_rst_valid", 32'(ch_valid), 32'h1);
        check("post_rst_head", 32'(ch_data[7:0]), 32'h3C);
        ch_ready = 2'b01;
        cyc();

        // Randomised traffic
        for (int it = 0; it < 1500; it++) begin
            if (it == 750) do_reset();
            if ($urandom_range(1, 0) == 1) la_in_toggle = ~la_in_toggle;
            la_in_sel  = ($urandom_range(9, 0) == 0) ? SEL_W'($urandom_range(3, 2))
                                                     : SEL_W'($urandom_range(1, 0));
            la_in_data = DATA_W'($urandom);
            ch_ready   = NUM_CH'($urandom);
            res_valid  = ($urandom_range(2, 0) != 0);
            res_data   = RES_W'($urandom);
            if ($urandom_range(2, 0) == 0) la_res_pop_toggle = ~la_res_pop_toggle;
            la_clr     = ($urandom_range(19, 0) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
